// File: rtl/trolley_system_led_ctrl_if.sv
// Avalon-MM s1 slave bus for the trolley LED bank controller.
// Ports: address/chipselect/write_n/writedata from the master,
//        readdata (combinational, zero wait states) from the slave.
interface trolley_system_led_ctrl_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/trolley_system_led_ctrl.sv
// LED bank output port: PIO-style DATA register, atomic set/clear/toggle,
// per-bit blink mask and a programmable blink half-period engine.
// Ports: clk, reset (sync, active-high), s1 (Avalon-MM slave bus),
//        out_port (registered LED drive, WIDTH bits).
module trolley_system_led_ctrl #(
   parameter int unsigned     WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [31:0]     PERIOD_RESET = 32'd25000000
) (
   input  logic                  clk,
   input  logic                  reset,
   trolley_system_led_ctrl_if.slave s1,
   output logic [WIDTH-1:0]      out_port
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_BLINK  = 3'd1;
   localparam logic [2:0] ADDR_SET    = 3'd2;
   localparam logic [2:0] ADDR_CLEAR  = 3'd3;
   localparam logic [2:0] ADDR_TOGGLE = 3'd4;
   localparam logic [2:0] ADDR_PERIOD = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] blink_q, blink_d;
   logic [31:0]      period_q, period_d;
   logic [31:0]      cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic [WIDTH-1:0] out_q, out_d;

   logic             wr_c;
   logic [WIDTH-1:0] wd_c;
   logic [31:0]      rdata_c;

   // Register writes, blink engine and output mask
   always_comb begin
      data_d   = data_q;
      blink_d  = blink_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;

      wr_c = s1.chipselect & ~s1.write_n;
      wd_c = WIDTH'(s1.writedata);

      // PERIOD = 0 halts the engine with the phase held
      if (period_q == 32'd0) begin
         cnt_d = 32'd0;
      end else if (cnt_q == period_q - 32'd1) begin
         cnt_d   = 32'd0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end

      if (wr_c) begin
         case (s1.address)
            ADDR_DATA:   data_d  = wd_c;
            ADDR_BLINK:  blink_d = wd_c;
            ADDR_SET:    data_d  = data_q | wd_c;
            ADDR_CLEAR:  data_d  = data_q & ~wd_c;
            ADDR_TOGGLE: data_d  = data_q ^ wd_c;
            ADDR_PERIOD: begin
               // Restart on a fresh on-phase; overrides a same-cycle terminal count
               period_d = s1.writedata;
               cnt_d    = 32'd0;
               phase_d  = 1'b1;
            end
            default: ;
         endcase
      end

      out_d = data_q & ~(blink_q & {WIDTH{~phase_q}});
   end

   // Zero-latency read mux
   always_comb begin
      rdata_c = 32'd0;
      case (s1.address)
         ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE: rdata_c = 32'(data_q);
         ADDR_BLINK:  rdata_c = 32'(blink_q);
         ADDR_PERIOD: rdata_c = period_q;
         ADDR_STATUS: rdata_c = {31'd0, phase_q};
         default:     rdata_c = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= RESET_VALUE;
         blink_q  <= '0;
         period_q <= PERIOD_RESET;
         cnt_q    <= 32'd0;
         phase_q  <= 1'b1;
         out_q    <= RESET_VALUE;
      end else begin
         data_q   <= data_d;
         blink_q  <= blink_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         out_q    <= out_d;
      end
   end

   assign s1.readdata = rdata_c;
   assign out_port    = out_q;

endmodule

// File: tb/tb_trolley_system_led_ctrl.sv
// Directed bench for trolley_system_led_ctrl (WIDTH=8, RESET_VALUE=0x3C).
// The driver pushes expected readdata/out_port values tagged with the cycle
// they belong to; the monitor pops and compares them at the falling edge.
module tb_trolley_system_led_ctrl;

   typedef struct {
      int          cyc;
      bit          is_rd;
      logic [31:0] val;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [7:0] out_port;

   trolley_system_led_ctrl_if bus ();

   trolley_system_led_ctrl #(
      .WIDTH       (8),
      .RESET_VALUE (8'h3C)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s1       (bus.slave),
      .out_port (out_port)
   );

   exp_t  exp_q[$];
   string name_q[$];
   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;
   bit    done  = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation queued for the current cycle
   always @(negedge clk) begin
      exp_t        e;
      string       nm;
      logic [31:0] act;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         total++;
         if (e.cyc < cyc) begin
            bad++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", nm, e.cyc, cyc);
         end else begin
            act = e.is_rd ? bus.readdata : 32'(out_port);
            if (act !== e.val) begin
               bad++;
               $display("FAIL %s: cycle %0d got %h want %h", nm, cyc, act, e.val);
            end
         end
      end
      if (done) begin
         while (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", nm, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.address    = 3'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'd0;
   endtask

   task automatic expect_val(input string nm, input bit is_rd, input logic [31:0] v);
      exp_t e;
      e.cyc   = cyc;
      e.is_rd = is_rd;
      e.val   = v;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Present a read this cycle and queue the expected readdata
   task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] v);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      expect_val(nm, 1'b1, v);
   endtask

   task automatic chk_out(input string nm, input logic [31:0] v);
      expect_val(nm, 1'b0, v);
   endtask

   // Write accepted at the next edge; returns in the following cycle with the bus idle
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = d;
      tick();
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk_out("rst_out", 32'h3C);
      rd("rst_data", 3'd0, 32'h0000003C);   tick();
      rd("rst_period", 3'd5, 32'd25000000); tick();
      rd("rst_status", 3'd6, 32'd1);        tick();
      rd("rst_addr7", 3'd7, 32'd0);         tick();

      // DATA write / readback
      wr(3'd0, 32'hA5);
      rd("data_rd", 3'd0, 32'hA5);
      chk_out("data_out_old", 32'h3C);
      tick();
      chk_out("data_out_new", 32'hA5);
      wr(3'd0, 32'h1FF);
      rd("data_trunc", 3'd0, 32'hFF);       tick();
      bus.address    = 3'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b0;
      bus.writedata  = 32'h12;
      tick();
      idle();
      rd("data_no_cs", 3'd0, 32'hFF);       tick();

      // Atomic set / clear / toggle
      wr(3'd0, 32'hA0);
      wr(3'd2, 32'h0F);
      rd("set_rd0", 3'd0, 32'hAF);          tick();
      rd("set_rd2", 3'd2, 32'hAF);          tick();
      wr(3'd3, 32'h81);
      rd("clr_rd3", 3'd3, 32'h2E);          tick();
      wr(3'd4, 32'hFF);
      rd("tgl_rd4", 3'd4, 32'hD1);          tick();

      // Blink with PERIOD = 4; phase runs one cycle ahead of out_port
      wr(3'd0, 32'hFF);
      wr(3'd1, 32'h0F);
      rd("blink_rd1", 3'd1, 32'h0F);        tick();
      wr(3'd5, 32'd4);
      tick();
      for (int i = 0; i < 16; i++) begin
         rd("blink_status", 3'd6, (((i + 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
         chk_out("blink_out", ((i / 4) % 2 == 0) ? 32'hFF : 32'hF0);
         tick();
      end

      // PERIOD = 1: toggle every cycle
      wr(3'd5, 32'd1);
      tick();
      for (int i = 0; i < 8; i++) begin
         rd("p1_status", 3'd6, (i % 2 == 1) ? 32'd1 : 32'd0);
         chk_out("p1_out", (i % 2 == 0) ? 32'hFF : 32'hF0);
         tick();
      end

      // PERIOD = 0: engine frozen
      wr(3'd5, 32'd0);
      tick();
      for (int i = 0; i < 100; i++) begin
         chk_out("p0_out", 32'hFF);
         if (i % 10 == 0) rd("p0_status", 3'd6, 32'd1);
         tick();
         idle();
      end

      // PERIOD = 2 to reach an off-phase, then rewrite PERIOD = 4
      // on the same edge as a terminal count
      wr(3'd5, 32'd2);
      tick();
      rd("p2_status_on", 3'd6, 32'd1);      tick();
      rd("p2_status_off", 3'd6, 32'd0);     tick();
      wr(3'd5, 32'd4);
      rd("rewr_status", 3'd6, 32'd1);
      chk_out("rewr_out_off", 32'hF0);
      tick();
      for (int i = 0; i < 5; i++) begin
         rd("rewr_status_run", 3'd6, (i < 3) ? 32'd1 : 32'd0);
         chk_out("rewr_out_run", (i < 4) ? 32'hFF : 32'hF0);
         tick();
      end

      // Reset during off-phase with a simultaneous SET write
      reset          = 1'b1;
      bus.address    = 3'd2;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = 32'hFF;
      tick();
      reset = 1'b0;
      idle();
      chk_out("mid_rst_out", 32'h3C);
      rd("mid_rst_data", 3'd0, 32'h3C);     tick();
      rd("mid_rst_blink", 3'd1, 32'd0);     tick();
      rd("mid_rst_status", 3'd6, 32'd1);    tick();
      rd("mid_rst_period", 3'd5, 32'd25000000);
      chk_out("mid_rst_out2", 32'h3C);
      tick();
      idle();

      tick();
      done = 1'b1;
      tick();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
